// File: rtl/alu_pkg.sv
// Shared types for the ALU execute unit: operation codes, ALUOp encodings, FSM states and the decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL,
    OP_SRL, OP_SRA, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } alu_op_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  function automatic alu_op_e decode(input logic [1:0] alu_op, input logic op5,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input bit en_m);
    alu_op_e op;
    op = OP_ILL;
    case (alu_op)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_FUNCT: begin
        if (op5 && f7 == F7_MULDIV) begin
          if (en_m) begin
            case (f3)
              3'b000:  op = OP_MUL;
              3'b100:  op = OP_DIV;
              3'b101:  op = OP_DIVU;
              3'b110:  op = OP_REM;
              3'b111:  op = OP_REMU;
              default: op = OP_ILL;
            endcase
          end
        // R-type only tolerates the alternate funct7 on SUB and SRA
        end else if (op5 && f7 != F7_BASE &&
                     !(f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
          op = OP_ILL;
        end else begin
          case (f3)
            3'b000:  op = (op5 && f7[5]) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = f7[5] ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/result handshake bundle between the decoder, the ALU execute unit and writeback.
interface alu_exec_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic            OP_5;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ALUResult;
  logic            Zero;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, ALUOp, OP_5, funct3, funct7, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, illegal, busy
  );

  modport slave (
    input  in_valid, ALUOp, OP_5, funct3, funct7, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, illegal, busy
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle for XLEN cycles.
// done_o marks the final step; result_o is valid alongside it.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN) + 1;

  logic            active_q, active_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  alu_op_e         op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d, q_q, q_d, d_q, d_d;
  logic            negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

  logic            is_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, quot, rem;
  logic [XLEN:0]   rem_sh, diff;

  assign is_signed = (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_neg     = is_signed && a_i[XLEN-1];
  assign b_neg     = is_signed && b_i[XLEN-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;
  assign rem_sh    = {acc_q, q_q[XLEN-1]};
  assign diff      = rem_sh - {1'b0, d_q};
  assign done_o    = active_q && (cnt_q == CW'(1));

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    q_d      = q_q;
    d_d      = d_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = CW'(XLEN);
      op_d     = op_i;
      acc_d    = '0;
      q_d      = (op_i == OP_MUL) ? b_i : a_mag;
      d_d      = (op_i == OP_MUL) ? a_i : b_mag;
      negq_d   = a_neg ^ b_neg;
      negr_d   = a_neg;
      dz_d     = (b_i == '0);
    end else if (active_q) begin
      if (op_q == OP_MUL) begin
        if (q_q[0]) acc_d = acc_q + d_q;
        d_d = d_q << 1;
        q_d = q_q >> 1;
      end else if (!diff[XLEN]) begin
        acc_d = diff[XLEN-1:0];
        q_d   = {q_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[XLEN-1:0];
        q_d   = {q_q[XLEN-2:0], 1'b0};
      end
      cnt_d    = cnt_q - 1'b1;
      active_d = (cnt_q != CW'(1));
    end
    // Divide-by-zero quotient is all-ones regardless of operand signs
    quot = dz_q ? '1 : (negq_q ? -q_d : q_d);
    rem  = negr_q ? -acc_d : acc_d;
    case (op_q)
      OP_MUL:          result_o = acc_d;
      OP_DIV, OP_DIVU: result_o = quot;
      default:         result_o = rem;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      q_q      <= '0;
      d_q      <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      d_q      <= d_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/funct fields, runs single-cycle ops or the iterative mul/div,
// and presents a registered result held until the consumer takes it.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic CLK,
  input logic RST,
  alu_exec_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

  alu_op_e         op;
  logic            accept, is_md, md_start, md_done;
  logic [XLEN-1:0] md_result, alu_res, a, b;
  logic [SHW-1:0]  shamt;

  assign a     = bus.SrcA;
  assign b     = bus.SrcB;
  assign shamt = b[SHW-1:0];
  assign op    = decode(bus.ALUOp, bus.OP_5, bus.funct3, bus.funct7, ENABLE_M);
  assign is_md = op inside {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_BUSY);
  assign bus.ALUResult = result_q;
  assign bus.Zero      = (result_q == '0);
  assign bus.illegal   = illegal_q;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    md_start  = 1'b0;
    case (state_q)
      ST_BUSY: begin
        if (md_done) begin
          state_d   = ST_DONE;
          result_d  = md_result;
          illegal_d = 1'b0;
        end
      end
      default: begin
        if (accept) begin
          illegal_d = (op == OP_ILL);
          if (is_md) begin
            state_d  = ST_BUSY;
            md_start = 1'b1;
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
          end
        end else if (state_q == ST_DONE && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk_i    (CLK),
    .rst_i    (RST),
    .start_i  (md_start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .done_o   (md_done),
    .result_o (md_result)
  );
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN=32, with and without the M extension).
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_exec_unit_if #(.XLEN(32)) bus ();
  alu_exec_unit_if #(.XLEN(32)) bus_nm ();

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut    (.CLK(clk), .RST(rst), .bus(bus));
  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (.CLK(clk), .RST(rst), .bus(bus_nm));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] aop, input logic op5, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    bus.ALUOp    = aop;
    bus.OP_5     = op5;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.SrcA     = a;
    bus.SrcB     = b;
    bus.in_valid = 1'b1;
  endtask

  task automatic issue(input logic [1:0] aop, input logic op5, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    drive(aop, op5, f3, f7, a, b);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.ALUOp = 2'b00; bus.OP_5 = 1'b0; bus.funct3 = 3'b0; bus.funct7 = 7'b0;
    bus.SrcA = '0; bus.SrcB = '0;
    bus_nm.in_valid = 1'b0; bus_nm.out_ready = 1'b1;
    bus_nm.ALUOp = 2'b00; bus_nm.OP_5 = 1'b0; bus_nm.funct3 = 3'b0; bus_nm.funct7 = 7'b0;
    bus_nm.SrcA = '0; bus_nm.SrcB = '0;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1 ||
        bus.illegal !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: vld=%b res=%h zero=%b ill=%b busy=%b rdy=%b, want 0 00000000 1 0 0 1",
               bus.out_valid, bus.ALUResult, bus.Zero, bus.illegal, bus.busy, bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_simple_ops();
    logic [1:0]  aop[8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
    logic        op5[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3[8]  = '{3'b000, 3'b101, 3'b101, 3'b001, 3'b000, 3'b111, 3'b000, 3'b010};
    logic [6:0]  f7[8]  = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
    logic [31:0] a[8]   = '{32'd5, 32'h80000000, 32'h80000000, 32'd1, 32'd5, 32'hF0F0, 32'd3, 32'hFFFFFFFF};
    logic [31:0] b[8]   = '{32'd7, 32'd4, 32'd4, 32'h21, 32'd7, 32'hFF00, 32'hFFFFFFFD, 32'd1};
    logic [31:0] exp[8] = '{32'hFFFFFFFE, 32'hF8000000, 32'h08000000, 32'd2, 32'd12, 32'hF000, 32'd0, 32'd1};
    string       nm[8]  = '{"sub", "sra", "srl", "sll_shamt_wrap", "itype_add", "and", "add_zero", "slt"};
    for (int i = 0; i < 8; i++) begin
      issue(aop[i], op5[i], f3[i], f7[i], a[i], b[i]);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.ALUResult !== exp[i] || bus.Zero !== (exp[i] == 0) ||
          bus.illegal !== 1'b0) begin
        errors++;
        $display("FAIL %s: vld=%b res=%h zero=%b ill=%b, want 1 %h %b 0",
                 nm[i], bus.out_valid, bus.ALUResult, bus.Zero, bus.illegal, exp[i], exp[i] == 0);
      end
    end
  endtask

  task automatic test_mul();
    int edges, busy_cycles;
    issue(2'b10, 1'b1, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd3);
    edges = 1;
    busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      step();
      edges++;
      if (bus.busy === 1'b1) busy_cycles++;
    end
    checks++;
    if (edges != 33 || busy_cycles != 32 || bus.ALUResult !== 32'hFFFFFFFD || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL mul: edges=%0d busy=%0d res=%h ill=%b, want 33 32 fffffffd 0",
               edges, busy_cycles, bus.ALUResult, bus.illegal);
    end
  endtask

  task automatic test_divide();
    logic [2:0]  f3[8]  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] a[8]   = '{32'h80000000, 32'h80000000, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFB, 32'hFFFFFFFB};
    logic [31:0] b[8]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'd2, 32'd0, 32'd0};
    logic [31:0] exp[8] = '{32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
    string       nm[8]  = '{"div_ovf", "rem_ovf", "divu_zero", "remu_zero", "div_neg", "rem_neg", "div_neg_zero", "rem_neg_zero"};
    int n;
    for (int i = 0; i < 8; i++) begin
      issue(2'b10, 1'b1, f3[i], 7'h01, a[i], b[i]);
      wait_valid(40, n);
      checks++;
      if (n + 1 != 33 || bus.out_valid !== 1'b1 || bus.ALUResult !== exp[i]) begin
        errors++;
        $display("FAIL %s: edges=%0d vld=%b res=%h, want 33 1 %h",
                 nm[i], n + 1, bus.out_valid, bus.ALUResult, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [1:0] aop[3] = '{2'b11, 2'b10, 2'b10};
    logic [2:0] f3[3]  = '{3'b000, 3'b010, 3'b000};
    logic [6:0] f7[3]  = '{7'h00, 7'h01, 7'h02};
    string      nm[3]  = '{"aluop_rsvd", "m_f3_010", "bad_f7"};
    for (int i = 0; i < 3; i++) begin
      issue(aop[i], 1'b1, f3[i], f7[i], 32'd9, 32'd4);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1) begin
        errors++;
        $display("FAIL %s: vld=%b ill=%b res=%h zero=%b, want 1 1 00000000 1",
                 nm[i], bus.out_valid, bus.illegal, bus.ALUResult, bus.Zero);
      end
    end
    bus_nm.ALUOp = 2'b10; bus_nm.OP_5 = 1'b1; bus_nm.funct3 = 3'b000; bus_nm.funct7 = 7'h01;
    bus_nm.SrcA = 32'd6; bus_nm.SrcB = 32'd7; bus_nm.in_valid = 1'b1;
    step();
    bus_nm.in_valid = 1'b0;
    checks++;
    if (bus_nm.out_valid !== 1'b1 || bus_nm.illegal !== 1'b1 || bus_nm.ALUResult !== 32'h0 || bus_nm.busy !== 1'b0) begin
      errors++;
      $display("FAIL no_m_mul: vld=%b ill=%b res=%h busy=%b, want 1 1 00000000 0",
               bus_nm.out_valid, bus_nm.illegal, bus_nm.ALUResult, bus_nm.busy);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    issue(2'b00, 1'b0, 3'b000, 7'h00, 32'd10, 32'd20);
    drive(2'b10, 1'b1, 3'b111, 7'h00, 32'hF0, 32'h3C);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.ALUResult !== 32'd30 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: vld=%b res=%h rdy=%b, want 1 0000001e 0",
                 i, bus.out_valid, bus.ALUResult, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUResult !== 32'h30) begin
      errors++;
      $display("FAIL release: vld=%b res=%h, want 1 00000030", bus.out_valid, bus.ALUResult);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  aop[4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    logic [2:0]  f3[4]  = '{3'b100, 3'b110, 3'b011, 3'b000};
    logic [31:0] a[4]   = '{32'hFF, 32'hF00, 32'd1, 32'd3};
    logic [31:0] b[4]   = '{32'h0F, 32'h0F, 32'hFFFFFFFF, 32'd5};
    logic [31:0] exp[4] = '{32'hF0, 32'hF0F, 32'd1, 32'hFFFFFFFE};
    for (int i = 0; i < 4; i++) begin
      drive(aop[i], 1'b1, f3[i], 7'h00, a[i], b[i]);
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.ALUResult !== exp[i]) begin
        errors++;
        $display("FAIL b2b_%0d: vld=%b res=%h, want 1 %h", i, bus.out_valid, bus.ALUResult, exp[i]);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_busy();
    issue(2'b10, 1'b1, 3'b000, 7'h01, 32'd5, 32'd6);
    repeat (9) step();
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_mid: busy=%b vld=%b, want 1 0", bus.busy, bus.out_valid);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.ALUResult !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy: vld=%b busy=%b rdy=%b res=%h, want 0 0 1 00000000",
               bus.out_valid, bus.busy, bus.in_ready, bus.ALUResult);
    end
    rst = 1'b0;
    issue(2'b00, 1'b0, 3'b000, 7'h00, 32'd2, 32'd2);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUResult !== 32'd4) begin
      errors++;
      $display("FAIL after_rst: vld=%b res=%h, want 1 00000004", bus.out_valid, bus.ALUResult);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_simple_ops();
    test_mul();
    test_divide();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
